// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: instruction types, ALU op codes,
// field positions and the decoded-control bundle. CU_ILLEGAL_TRAP_EN adds the trap flag.
package isa_pkg;

    typedef enum logic [1:0] {
        TYPE_R   = 2'b00,
        TYPE_I   = 2'b01,
        TYPE_MEM = 2'b10,
        TYPE_JMP = 2'b11
    } instr_type_e;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1011;

    localparam int unsigned TYPE_MSB  = 31;
    localparam int unsigned TYPE_LSB  = 30;
    localparam int unsigned F_MSB     = 29;
    localparam int unsigned F_LSB     = 26;
    localparam int unsigned RD_MSB    = 25;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS1_MSB   = 21;
    localparam int unsigned RS1_LSB   = 18;
    localparam int unsigned RS2_MSB   = 17;
    localparam int unsigned RS2_LSB   = 14;
    localparam int unsigned IMM_MSB   = 17;
    localparam int unsigned TGT_MSB   = 25;
    localparam int unsigned MEM_ST    = 29;
    localparam int unsigned MEM_R_MSB = 28;
    localparam int unsigned MEM_R_LSB = 26;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  reg_read_address1;
        logic [3:0]  reg_read_address2;
        logic        reg_write_enable;
        logic [3:0]  reg_write_address;
        logic        immidiate_en;
        logic [31:0] immidiate_data;
        logic        jump_en;
        logic [31:0] jump_address;
        logic        mem_load;
        logic        mem_store;
`ifdef CU_ILLEGAL_TRAP_EN
        logic        illegal_instr;
`endif
    } ctrl_t;

    function automatic logic [31:0] sign_extend18(input logic [17:0] imm);
        return {{14{imm[17]}}, imm};
    endfunction

    function automatic logic is_reserved_op(input logic [3:0] f);
        return f > ALU_PASS_B;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Fetch-to-decode bus: instruction in, registered decode outputs back.
// illegal_instr exists only when CU_ILLEGAL_TRAP_EN is defined.
interface control_unit_if;
    logic [31:0] instruction;
    logic [3:0]  op;
    logic [3:0]  reg_read_address1;
    logic [3:0]  reg_read_address2;
    logic        reg_write_enable;
    logic [3:0]  reg_write_address;
    logic        immidiate_en;
    logic [31:0] immidiate_data;
    logic        jump_en;
    logic [31:0] jump_address;
    logic        mem_load;
    logic        mem_store;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    modport master (
        output instruction,
        input  op, reg_read_address1, reg_read_address2, reg_write_enable,
               reg_write_address, immidiate_en, immidiate_data, jump_en,
               jump_address, mem_load, mem_store
`ifdef CU_ILLEGAL_TRAP_EN
        , input illegal_instr
`endif
    );

    modport slave (
        input  instruction,
        output op, reg_read_address1, reg_read_address2, reg_write_enable,
               reg_write_address, immidiate_en, immidiate_data, jump_en,
               jump_address, mem_load, mem_store
`ifdef CU_ILLEGAL_TRAP_EN
        , output illegal_instr
`endif
    );
endinterface

// File: rtl/instr_decode_comb.sv
// Pure combinational instruction decode into ctrl_t.
// CU_ILLEGAL_TRAP_EN flags reserved encodings and suppresses their enables.
module instr_decode_comb
    import isa_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    instr_type_e itype;
    logic [3:0]  f;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic [31:0] tgt;

    assign itype = instr_type_e'(instruction[TYPE_MSB:TYPE_LSB]);
    assign f     = instruction[F_MSB:F_LSB];
    assign rd    = instruction[RD_MSB:RD_LSB];
    assign rs1   = instruction[RS1_MSB:RS1_LSB];
    assign rs2   = instruction[RS2_MSB:RS2_LSB];
    assign imm   = sign_extend18(instruction[IMM_MSB:0]);
    assign tgt   = {6'b0, instruction[TGT_MSB:0]};

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal;

    always_comb begin
        illegal = 1'b0;
        unique case (itype)
            TYPE_R, TYPE_I: illegal = is_reserved_op(f);
            TYPE_MEM:       illegal = instruction[MEM_R_MSB:MEM_R_LSB] != 3'b000;
            TYPE_JMP:       illegal = f != 4'b0000;
            default:        illegal = 1'b0;
        endcase
    end
`endif

    always_comb begin
        ctrl = '0;
        unique case (itype)
            TYPE_R: begin
                ctrl.op                = f;
                ctrl.reg_write_address = rd;
                ctrl.reg_read_address1 = rs1;
                ctrl.reg_read_address2 = rs2;
                ctrl.reg_write_enable  = 1'b1;
            end
            TYPE_I: begin
                ctrl.op                = f;
                ctrl.reg_write_address = rd;
                ctrl.reg_read_address1 = rs1;
                ctrl.immidiate_en      = 1'b1;
                ctrl.immidiate_data    = imm;
                ctrl.reg_write_enable  = 1'b1;
            end
            TYPE_MEM: begin
                // Effective address is always rs1 + imm through the ALU adder.
                ctrl.op                = ALU_ADD;
                ctrl.reg_read_address1 = rs1;
                ctrl.immidiate_en      = 1'b1;
                ctrl.immidiate_data    = imm;
                if (instruction[MEM_ST]) begin
                    ctrl.mem_store         = 1'b1;
                    ctrl.reg_read_address2 = rd;
                end else begin
                    ctrl.mem_load          = 1'b1;
                    ctrl.reg_write_enable  = 1'b1;
                    ctrl.reg_write_address = rd;
                end
            end
            TYPE_JMP: begin
                ctrl.jump_en      = 1'b1;
                ctrl.jump_address = tgt;
            end
            default: ctrl = '0;
        endcase

`ifdef CU_ILLEGAL_TRAP_EN
        ctrl.illegal_instr = illegal;
        if (illegal) begin
            ctrl.reg_write_enable = 1'b0;
            ctrl.immidiate_en     = 1'b0;
            ctrl.jump_en          = 1'b0;
            ctrl.mem_load         = 1'b0;
            ctrl.mem_store        = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/control_unit.sv
// Decode stage: combinational decode followed by one output register with sync active-low reset.
// CU_ILLEGAL_TRAP_EN enables the registered illegal_instr output.
module control_unit
    import isa_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);

    ctrl_t decoded;
    ctrl_t ctrl_q;

    instr_decode_comb u_decode (
        .instruction (bus.instruction),
        .ctrl        (decoded)
    );

    // Reset loads a NOP: every output field zero.
    always_ff @(posedge clk) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= decoded;
    end

    assign bus.op                = ctrl_q.op;
    assign bus.reg_read_address1 = ctrl_q.reg_read_address1;
    assign bus.reg_read_address2 = ctrl_q.reg_read_address2;
    assign bus.reg_write_enable  = ctrl_q.reg_write_enable;
    assign bus.reg_write_address = ctrl_q.reg_write_address;
    assign bus.immidiate_en      = ctrl_q.immidiate_en;
    assign bus.immidiate_data    = ctrl_q.immidiate_data;
    assign bus.jump_en           = ctrl_q.jump_en;
    assign bus.jump_address      = ctrl_q.jump_address;
    assign bus.mem_load          = ctrl_q.mem_load;
    assign bus.mem_store         = ctrl_q.mem_store;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal_instr     = ctrl_q.illegal_instr;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected decode pushed at drive time, popped one cycle later.
// Honours CU_ILLEGAL_TRAP_EN for the trap output and reserved-op expectations.
module tb_control_unit;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        we;
        logic [3:0]  wa;
        logic        ie;
        logic [31:0] id;
        logic        je;
        logic [31:0] ja;
        logic        ml;
        logic        ms;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t sb[$];

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic we, input logic [3:0] wa, input logic ie,
                                input logic [31:0] id, input logic je, input logic [31:0] ja,
                                input logic ml, input logic ms, input logic ill);
        exp_t e;
        e = '{op, ra1, ra2, we, wa, ie, id, je, ja, ml, ms, ill};
        return e;
    endfunction

    // Independent reference decode of one instruction word.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [31:0] sx;
        logic ill;
        e = '0;
        ill = 1'b0;
        sx = w[17] ? {14'h3FFF, w[17:0]} : {14'h0, w[17:0]};
        if (w[31] == 1'b0) begin
            e.op = w[29:26]; e.wa = w[25:22]; e.ra1 = w[21:18]; e.we = 1'b1;
            if (w[30]) begin e.ie = 1'b1; e.id = sx; end
            else e.ra2 = w[17:14];
            ill = (w[29:28] == 2'b11);
        end else if (w[30] == 1'b0) begin
            e.ra1 = w[21:18]; e.ie = 1'b1; e.id = sx;
            if (w[29]) begin e.ms = 1'b1; e.ra2 = w[25:22]; end
            else begin e.ml = 1'b1; e.we = 1'b1; e.wa = w[25:22]; end
            ill = (w[28:26] != 3'b000);
        end else begin
            e.je = 1'b1; e.ja = {6'b0, w[25:0]};
            ill = (w[29:26] != 4'b0000);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        if (ill) begin
            e.ill = 1'b1; e.we = 1'b0; e.ie = 1'b0; e.je = 1'b0; e.ml = 1'b0; e.ms = 1'b0;
        end
`else
        if (ill) e.ill = 1'b0;
`endif
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check_eq("op",  {28'h0, bus.op},                e.op);
        check_eq("ra1", {28'h0, bus.reg_read_address1}, e.ra1);
        check_eq("ra2", {28'h0, bus.reg_read_address2}, e.ra2);
        check_eq("we",  {31'h0, bus.reg_write_enable},  e.we);
        check_eq("wa",  {28'h0, bus.reg_write_address}, e.wa);
        check_eq("ie",  {31'h0, bus.immidiate_en},      e.ie);
        check_eq("id",  bus.immidiate_data,             e.id);
        check_eq("je",  {31'h0, bus.jump_en},           e.je);
        check_eq("ja",  bus.jump_address,               e.ja);
        check_eq("ml",  {31'h0, bus.mem_load},          e.ml);
        check_eq("ms",  {31'h0, bus.mem_store},         e.ms);
`ifdef CU_ILLEGAL_TRAP_EN
        check_eq("ill", {31'h0, bus.illegal_instr},     e.ill);
`endif
    endtask

    // Compare the output registered by the previous edge, then drive the next input.
    task automatic step(input logic rn, input logic [31:0] ins, input exp_t e);
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        rst_n = rn;
        bus.instruction = ins;
        sb.push_back(e);
    endtask

    initial begin
        logic [31:0] w;
        logic rn;
        exp_t nop;
        nop = '0;
        bus.instruction = 32'hFFFF_FFFF;

        step(1'b0, 32'hFFFF_FFFF, nop);
        step(1'b0, 32'h1234_5678, nop);
        step(1'b1, 32'h0000_0000, mk(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h0448_C000, mk(4'h1, 4'h2, 4'h3, 1'b1, 4'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h415B_FFFF, mk(4'h0, 4'h6, 4'h0, 1'b1, 4'h5, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h80D0_0010, mk(4'h0, 4'h4, 4'h0, 1'b1, 4'h3, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'hA0D0_0010, mk(4'h0, 4'h4, 4'h3, 1'b0, 4'h0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        step(1'b1, 32'hC000_0100, mk(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h80D0_0010, mk(4'h0, 4'h4, 4'h0, 1'b1, 4'h3, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'hC000_0100, mk(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0));
`ifdef CU_ILLEGAL_TRAP_EN
        step(1'b1, 32'h3C00_0000, mk(4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
`else
        step(1'b1, 32'h3C00_0000, mk(4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
`endif
        step(1'b0, 32'h415B_FFFF, nop);
        step(1'b1, 32'h415B_FFFF, mk(4'h0, 4'h6, 4'h0, 1'b1, 4'h5, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h4000_1FFF, mk(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 32'h0000_1FFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'hC3FF_FFFF, model(32'hC3FF_FFFF));

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            rn = ($urandom_range(0, 15) != 0);
            step(rn, w, rn ? model(w) : nop);
        end

        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
